// File: rtl/sdsu_bus_slave.sv
// sdsu_bus_slave: read-only SDSU bus target answering from a synthetic lookup table after a fixed latency.
// Define SDSU_SLAVE_STATS_EN to expose transaction/abort counters at the two words just past the table.
module sdsu_bus_slave #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
   parameter int unsigned DEPTH     = 256,
   parameter int unsigned LATENCY   = 2,
   parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_valid,
   input  logic        i_start,
   input  logic [31:0] i_address,
   output logic        o_ready,
   output logic [31:0] o_result_data
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
`ifdef SDSU_SLAVE_STATS_EN
   localparam int unsigned STATS_WORDS = 2;
`else
   localparam int unsigned STATS_WORDS = 0;
`endif
   localparam logic [63:0] END_ADDR = 64'(BASE_ADDR) + 64'(DEPTH + STATS_WORDS) * 64'd4;
   if (DEPTH < 1 || DEPTH > 65536 || LATENCY < 1 || LATENCY > 15 || END_ADDR > 64'h1_0000_0000) begin : g_bad_cfg
      $error("sdsu_bus_slave: illegal DEPTH/LATENCY or decoded window wraps the address space");
   end
   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [31:0] r_addr;
   logic [31:0] w_off;
   logic        w_word;
   logic        w_hit;
   logic [31:0] w_data;
   assign w_off  = r_addr - BASE_ADDR;
   assign w_word = r_addr >= BASE_ADDR && w_off[1:0] == 2'b00;
   assign w_hit  = w_word && 32'(w_off[31:2]) < DEPTH;
`ifdef SDSU_SLAVE_STATS_EN
   logic [31:0] r_txn_cnt;
   logic [31:0] r_abort_cnt;
   logic        w_abort;
   assign w_abort = r_state == WAIT && !i_valid;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_txn_cnt   <= '0;
         r_abort_cnt <= '0;
      end else begin
         if (r_state == RESP && r_txn_cnt != '1) r_txn_cnt <= r_txn_cnt + 32'd1;
         if (w_abort && r_abort_cnt != '1) r_abort_cnt <= r_abort_cnt + 32'd1;
      end
   end
   // the txn counter is sampled one edge before it counts the current RESP
   assign w_data = w_hit ? {16'hC0DE, w_off[17:2]} :
                   (w_word && 32'(w_off[31:2]) == DEPTH) ? r_txn_cnt :
                   (w_word && 32'(w_off[31:2]) == DEPTH + 32'd1) ? r_abort_cnt : ERR_DATA;
`else
   assign w_data = w_hit ? {16'hC0DE, w_off[17:2]} : ERR_DATA;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_cnt         <= '0;
         r_addr        <= '0;
         o_ready       <= 1'b0;
         o_result_data <= '0;
      end else begin
         o_ready <= 1'b0;
         case (r_state)
            IDLE:
               if (i_start && i_valid) begin
                  r_addr  <= i_address;
                  r_cnt   <= 4'(LATENCY);
                  r_state <= WAIT;
               end
            WAIT:
               if (!i_valid) r_state <= IDLE;
               else if (r_cnt == '0) begin
                  r_state       <= RESP;
                  o_ready       <= 1'b1;
                  o_result_data <= w_data;
               end else r_cnt <= r_cnt - 4'd1;
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sdsu_bus_slave.sv
// tb_sdsu_bus_slave: randomized read/abort traffic against a transaction-level model of the slave.
module tb_sdsu_bus_slave;
   localparam logic [31:0] BASE_ADDR = 32'h0000_1000;
   localparam int          DEPTH     = 256;
   localparam int          LATENCY   = 2;
   localparam logic [31:0] ERR_DATA  = 32'hDEAD_BEEF;
   localparam int          WIN       = 2 * LATENCY + 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid = 1'b0;
   logic        start = 1'b0;
   logic [31:0] address = '0;
   logic        ready;
   logic [31:0] result_data;

   int          n_vec = 0;
   int          n_err = 0;
   int unsigned n_txn = 0;
   int unsigned n_abort = 0;
   logic [31:0] last_data = '0;

   sdsu_bus_slave #(.BASE_ADDR(BASE_ADDR), .DEPTH(DEPTH), .LATENCY(LATENCY), .ERR_DATA(ERR_DATA)) dut (
      .clk(clk), .rst_n(rst_n), .i_valid(valid), .i_start(start), .i_address(address),
      .o_ready(ready), .o_result_data(result_data));

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [31:0] a, input int unsigned txn, input int unsigned ab);
      longint off;
      if (a < BASE_ADDR) return ERR_DATA;
      off = longint'(a) - longint'(BASE_ADDR);
      if (off % 4 != 0) return ERR_DATA;
      if (off / 4 < DEPTH) return {16'hC0DE, 16'(off / 4)};
`ifdef SDSU_SLAVE_STATS_EN
      if (off / 4 == DEPTH) return txn;
      if (off / 4 == DEPTH + 1) return ab;
`endif
      return ERR_DATA;
   endfunction

   // mode 0: plain read; 1: extra start&valid in WAIT; 2: extra start&valid on the RESP edge
   task automatic do_read(input logic [31:0] a, input int mode);
      logic [31:0] exp, got;
      int first, pulses;
      exp = model(a, n_txn, n_abort);
      got = '0;
      first = -1;
      pulses = 0;
      @(posedge clk); #1;
      start = 1'b1; valid = 1'b1; address = a;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k <= WIN; k++) begin
         if ((mode == 1 && k == 1) || (mode == 2 && k == LATENCY + 2)) begin
            start = 1'b1;
            address = a ^ 32'h0000_0044;
         end
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
         if (ready) begin
            pulses++;
            if (first < 0) begin
               first = k;
               got = result_data;
            end
         end
      end
      valid = 1'b0;
      chk($sformatf("latency@%h", a), first, LATENCY + 1);
      chk($sformatf("pulses@%h", a), pulses, 1);
      chk($sformatf("data@%h", a), got, exp);
      chk($sformatf("hold@%h", a), result_data, exp);
      n_txn++;
      last_data = exp;
   endtask

   // valid is seen low at the j-th edge after capture (1..LATENCY+1)
   task automatic do_abort(input logic [31:0] a, input int j);
      int pulses = 0;
      @(posedge clk); #1;
      start = 1'b1; valid = 1'b1; address = a;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k <= WIN; k++) begin
         if (k == j) valid = 1'b0;
         @(posedge clk);
         @(negedge clk);
         if (ready) pulses++;
      end
      chk($sformatf("abort_pulses@%h", a), pulses, 0);
      chk($sformatf("abort_hold@%h", a), result_data, last_data);
      n_abort++;
   endtask

   task automatic start_no_valid(input logic [31:0] a);
      int pulses = 0;
      @(posedge clk); #1;
      start = 1'b1; valid = 1'b0; address = a;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k <= WIN; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (ready) pulses++;
      end
      chk("nostart_pulses", pulses, 0);
      chk("nostart_hold", result_data, last_data);
   endtask

   task automatic reset_mid_wait(input logic [31:0] a);
      int pulses = 0;
      @(posedge clk); #1;
      start = 1'b1; valid = 1'b1; address = a;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("rst_ready", ready, 0);
      chk("rst_data", result_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= WIN; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (ready) pulses++;
      end
      valid = 1'b0;
      chk("rst_pulses", pulses, 0);
      n_txn = 0;
      n_abort = 0;
      last_data = '0;
   endtask

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 5))
         0: return BASE_ADDR + 32'(4 * $urandom_range(0, DEPTH - 1));
         1: return BASE_ADDR + 32'(4 * (DEPTH + $urandom_range(0, 2)));
         2: return BASE_ADDR + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
         3: return 32'($urandom_range(0, 32'(BASE_ADDR) - 1));
         4: return $urandom;
         default: return BASE_ADDR + 32'(4 * (DEPTH - 1));
      endcase
   endfunction

   initial begin
      #3;
      chk("reset_ready", ready, 0);
      chk("reset_data", result_data, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      do_read(32'h0000_1010, 0);
      do_read(32'h0000_13FC, 0);
      do_read(32'h0000_1400, 0);
      do_read(32'h0000_0FFC, 0);
      do_read(32'h0000_1002, 0);
      do_abort(32'h0000_1020, 1);
      do_read(32'h0000_1000, 0);
      start_no_valid(32'h0000_1030);
      do_read(32'h0000_1100, 1);
      do_read(32'h0000_1104, 2);
      reset_mid_wait(32'h0000_1008);
      do_read(32'h0000_1014, 0);
      do_read(32'h0000_1018, 0);
      do_read(32'h0000_101C, 0);
      do_abort(32'h0000_1024, 2);
      do_read(32'h0000_1400, 0);
      do_read(32'h0000_1404, 0);
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 7) == 0) do_abort(rand_addr(), $urandom_range(1, LATENCY + 1));
         else do_read(rand_addr(), $urandom_range(0, 2));
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/sdsu_bus_slave.md
Name: sdsu_bus_slave

Overview:
- Read-only target on the SDSU single-master bus.
- The master drives start, valid and address; this block decodes the address and returns a 32-bit word on result_data, qualified by a one-cycle ready pulse.
- Its data space is a synthetic lookup table with a programmable base, depth and fixed response latency. A bus testbench or SoC fabric uses it as a deterministic responder.

Parameters:
- BASE_ADDR, 32'h0000_1000, byte address of table word 0.
- DEPTH, 256, number of 32-bit words decoded (1..65536).
- LATENCY, 2, wait cycles between request capture and ready (1..15).
- ERR_DATA, 32'hDEAD_BEEF, value returned for undecoded or misaligned addresses.

Ports:
- clk  input  1  bus clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- valid  input  1  master request-qualifier; held high for the whole transaction.
- start  input  1  one-cycle pulse marking a new request.
- address  input  32  byte address, sampled with start.
- ready  output  1  one-cycle response strobe.
- result_data  output  32  read data; meaningful while ready=1, held afterwards.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, ready=0, result_data=0, wait counter=0, captured address=0. Takes effect immediately, including mid-transaction; the pending request is discarded.
- State IDLE:
  - start=1 and valid=1 at a rising edge: capture address, load counter with LATENCY, go to WAIT.
  - start without valid, or valid without start: ignored.
- State WAIT, at each rising edge:
  - valid=0: abort, go to IDLE, ready never asserted, result_data unchanged.
  - Otherwise decrement counter; when it reaches 0, go to RESP.
  - start pulses in WAIT or RESP are ignored (no queueing).
- State RESP: ready=1 for exactly one cycle, result_data registered on entry to RESP. Next edge returns to IDLE with ready=0. A new start&valid on that same edge is ignored; it must arrive while in IDLE.
- Timing: request captured at edge N puts ready high from edge N+LATENCY+1 to edge N+LATENCY+2. With LATENCY=2 that is 3 cycles from capture to ready.
- Decode:
  - off = address − BASE_ADDR (32-bit unsigned wrap).
  - Hit when address ≥ BASE_ADDR, off[1:0]=0 and off[31:2] < DEPTH.
  - On hit: idx = off[17:2] and result_data = {16'hC0DE, idx[15:0]}.
  - On miss or misalignment: result_data = ERR_DATA.
- Address space wrap: BASE_ADDR+4*DEPTH overflowing 32 bits is illegal configuration; the elaboration check fails.
- ready and result_data are registered outputs; no combinational path from inputs.

Optional Feature:
- Macro: SDSU_SLAVE_STATS_EN.
- Defined:
  - A 32-bit saturating transaction counter increments on every RESP cycle (hits and misses, not aborts). Reset value 0; holds at 32'hFFFF_FFFF.
  - The word at BASE_ADDR+4*DEPTH (one past the table) is decoded as a hit returning the counter value sampled before the current increment.
  - A second counter at BASE_ADDR+4*DEPTH+4 returns the abort count, same saturation rule.
- Not defined: no counters are synthesized; both addresses return ERR_DATA.

Test Plan:
- Reset mid-WAIT: assert rst_n=0 one cycle after capture -> ready stays 0, result_data=0, and the next request behaves normally.
- Basic read, defaults: start&valid with address=32'h0000_1010 -> ready high exactly one cycle, 3 cycles after capture; result_data=32'hC0DE_0004.
- Boundaries:
  - address=32'h0000_13FC -> 32'hC0DE_00FF.
  - 32'h0000_1400 -> 32'hDEAD_BEEF (without SDSU_SLAVE_STATS_EN).
  - 32'h0000_0FFC -> 32'hDEAD_BEEF.
  - 32'h0000_1002 -> 32'hDEAD_BEEF.
- Abort: valid dropped to 0 one cycle after capture -> no ready pulse, result_data retains the previous value. A following request to 32'h0000_1000 returns 32'hC0DE_0000.
- Ignored stimulus:
  - start without valid -> no response.
  - Second start&valid during WAIT with a different address -> only the first address is answered, one ready pulse total.
- Stats (SDSU_SLAVE_STATS_EN): 3 completed reads, 1 abort, then read 32'h0000_1400 -> 32'h0000_0003; then read 32'h0000_1404 -> 32'h0000_0001.
